// File: rtl/clk_div_prog.sv
// Programmable clock divider / clock-enable generator: power-of-two or integer
// period, glitch-free retune at period boundaries, plus a rising-edge tick.
module clk_div_prog #(
  parameter int CNT_W   = 26,
  parameter int SEL_W   = 2,
  parameter int TOP_BIT = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [CNT_W-1:0] div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             pending
);

  typedef struct packed {
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] div;
  } cfg_t;

  cfg_t             act, shd, cfg_in, shd_nxt;
  logic [CNT_W-1:0] per, low_len, cnt, cnt_nxt;
  logic             wrap;

  always_comb begin
    cfg_in  = '{mode: mode, sel: sel, div: div};
    shd_nxt = load ? cfg_in : shd;
    if (act.mode) per = (act.div < CNT_W'(2)) ? CNT_W'(2) : act.div;
    else          per = CNT_W'(1) << (TOP_BIT + 1 - int'(act.sel));
    // odd periods put the extra cycle in the low phase
    low_len = per - (per >> 1);
    wrap    = (cnt == per - CNT_W'(1));
    cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      o_clk   <= 1'b0;
      o_tick  <= 1'b0;
      pending <= 1'b0;
      act     <= '0;
      shd     <= '0;
    end else begin
      if (load) shd <= cfg_in;
      // shadow mirrors active whenever nothing is pending, so copying it
      // unconditionally at an apply point is harmless
      if (!en) begin
        cnt     <= '0;
        o_clk   <= 1'b0;
        o_tick  <= 1'b0;
        act     <= shd_nxt;
        pending <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        o_clk  <= (cnt_nxt >= low_len);
        o_tick <= (cnt_nxt == low_len);
        if (wrap) begin
          act     <= shd_nxt;
          pending <= 1'b0;
        end else if (load) begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues per-edge expected
// {o_clk, o_tick, pending}; a monitor pops and compares after every edge.
module tb_clk_div_prog;
  localparam int CNT_W = 8, SEL_W = 2, TOP_BIT = 4;

  logic             clk = 1'b0;
  logic             rst, en, load, mode;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] div;
  logic             o_clk, o_tick, pending;

  clk_div_prog #(.CNT_W(CNT_W), .SEL_W(SEL_W), .TOP_BIT(TOP_BIT)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode), .sel(sel),
    .div(div), .o_clk(o_clk), .o_tick(o_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  ck;
    logic  tk;
    logic  pd;
    string tag;
  } exp_t;

  exp_t  sb[$];
  int    n_chk = 0, n_pass = 0;
  string phase = "reset";

  // monitor: one comparison per edge while expectations are queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        if ({o_clk, o_tick, pending} === {e.ck, e.tk, e.pd}) n_pass++;
        else $display("FAIL %s @%0t: got clk/tick/pend=%b%b%b want %b%b%b",
                      e.tag, $time, o_clk, o_tick, pending, e.ck, e.tk, e.pd);
      end
    end
  end

  task automatic cyc(input logic ck, input logic tk, input logic pd);
    exp_t e;
    e = '{ck: ck, tk: tk, pd: pd, tag: phase};
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic ck, input logic pd);
    for (int i = 0; i < n; i++) cyc(ck, 1'b0, pd);
  endtask

  // one full period starting from phase 0: L-1 low, rise+tick, H-1 high, wrap low
  task automatic period(input int l, input int h, input logic pd);
    run(l - 1, 1'b0, pd);
    cyc(1'b1, 1'b1, pd);
    run(h - 1, 1'b1, pd);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cfg(input logic m, input logic [SEL_W-1:0] s, input logic [CNT_W-1:0] d);
    load = 1'b1; mode = m; sel = s; div = d;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; mode = 1'b0; sel = '0; div = '0;
    @(negedge clk);
    cyc(0, 0, 0);
    set_cfg(1, 0, 8'd9);           // load during reset must be discarded
    cyc(0, 0, 0);
    load = 1'b0;
    rst  = 1'b0;

    phase = "default_p32";
    period(16, 16, 0);
    period(16, 16, 0);

    phase = "load_div5";
    run(4, 0, 0);                  // now at c=4
    set_cfg(1, 0, 8'd5);
    cyc(0, 0, 1);                  // c=5, pending up
    load = 1'b0;
    run(10, 0, 1);
    cyc(1, 1, 1);
    run(15, 1, 1);
    cyc(0, 0, 0);                  // wrap applies div=5
    phase = "p5";
    period(3, 2, 0);
    period(3, 2, 0);
    period(3, 2, 0);

    phase = "two_loads";
    set_cfg(0, 2'd3, 8'd0);
    cyc(0, 0, 1);
    set_cfg(0, 2'd2, 8'd0);
    cyc(0, 0, 1);
    load = 1'b0;
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    phase = "p8";
    period(4, 4, 0);
    period(4, 4, 0);

    phase = "div0";
    set_cfg(1, 0, 8'd0);
    cyc(0, 0, 1);
    load = 1'b0;
    run(2, 0, 1);
    cyc(1, 1, 1);
    run(3, 1, 1);
    cyc(0, 0, 0);
    phase = "p2_div0";
    for (int i = 0; i < 3; i++) period(1, 1, 0);

    phase = "div1";
    set_cfg(1, 0, 8'd1);
    cyc(1, 1, 1);
    load = 1'b0;
    cyc(0, 0, 0);
    phase = "p2_div1";
    for (int i = 0; i < 3; i++) period(1, 1, 0);

    phase = "div7";
    set_cfg(1, 0, 8'd7);
    cyc(1, 1, 1);
    load = 1'b0;
    cyc(0, 0, 0);
    phase = "p7";
    period(4, 3, 0);

    phase = "en_drop";
    set_cfg(0, 2'd1, 8'd0);        // P=16 staged
    cyc(0, 0, 1);
    load = 1'b0;
    run(2, 0, 1);
    cyc(1, 1, 1);
    cyc(1, 0, 1);                  // high phase, pending
    en = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    en = 1'b1;
    phase = "p16_after_en";
    period(8, 8, 0);

    phase = "rst_mid";
    set_cfg(1, 0, 8'd3);
    cyc(0, 0, 1);
    load = 1'b0;
    run(6, 0, 1);
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    phase = "p32_after_rst";
    period(16, 16, 0);

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
